// File: rtl/fpu_dispatch_if.sv
// Unit-side bus bundle: operand, op and result AXI-Stream channels for a bank
// of floating-point operator units. Unit u occupies bit u of each valid/ready
// vector and slice [u*W +: W] of each data bus.
interface fpu_dispatch_if #(
  parameter int unsigned NUM_UNITS = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OP_W      = 8
);
  logic [NUM_UNITS*DATA_W-1:0] u_a_tdata;
  logic [NUM_UNITS-1:0]        u_a_tvalid;
  logic [NUM_UNITS-1:0]        u_a_tready;
  logic [NUM_UNITS*DATA_W-1:0] u_b_tdata;
  logic [NUM_UNITS-1:0]        u_b_tvalid;
  logic [NUM_UNITS-1:0]        u_b_tready;
  logic [NUM_UNITS*OP_W-1:0]   u_op_tdata;
  logic [NUM_UNITS-1:0]        u_op_tvalid;
  logic [NUM_UNITS-1:0]        u_op_tready;
  logic [NUM_UNITS*DATA_W-1:0] u_r_tdata;
  logic [NUM_UNITS-1:0]        u_r_tvalid;
  logic [NUM_UNITS-1:0]        u_r_tready;

  // Dispatcher side.
  modport master (
    output u_a_tdata, u_a_tvalid, u_b_tdata, u_b_tvalid,
    output u_op_tdata, u_op_tvalid, u_r_tready,
    input  u_a_tready, u_b_tready, u_op_tready, u_r_tdata, u_r_tvalid
  );

  // Operator-unit side.
  modport slave (
    input  u_a_tdata, u_a_tvalid, u_b_tdata, u_b_tvalid,
    input  u_op_tdata, u_op_tvalid, u_r_tready,
    output u_a_tready, u_b_tready, u_op_tready, u_r_tdata, u_r_tvalid
  );
endinterface

// File: rtl/fpu_dispatch.sv
// Single-issue dispatcher from the execute stage to a bank of AXI-Stream FP
// operator units. Accepts one request, issues operands (and op where the unit
// has one) with independent per-channel handshakes, waits for the result and
// reports it with a one-cycle done pulse. A watchdog aborts stuck units.
module fpu_dispatch #(
  parameter int unsigned          NUM_UNITS   = 7,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          OP_W        = 8,
  parameter logic [NUM_UNITS-1:0] OP_MASK     = 7'b0001001,
  parameter int unsigned          TIMEOUT_CYC = 1023,
  localparam int unsigned         UW          = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int unsigned         CW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  input  logic [UW-1:0]     req_unit,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  input  logic              stall,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        err,
  fpu_dispatch_if.master    u
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrTimeout = 2'b01;
  localparam logic [1:0] ErrIllegal = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [UW-1:0]     unit_q, unit_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              op_done_q, op_done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        err_q, err_d;

  logic              req_legal;
  logic              req_has_op;
  logic              sel_a_rdy, sel_b_rdy, sel_op_rdy, sel_r_vld;
  logic [DATA_W-1:0] sel_r_data;
  logic              a_fire, b_fire, op_fire, r_fire;
  logic              timeout;

  assign req_ready = (state_q == StIdle) && !stall;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign err       = err_q;

  assign req_legal = (32'(req_unit) < NUM_UNITS);
  // Counter value is cycles spent busy minus one, so this edge is the TIMEOUT_CYC-th.
  assign timeout   = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Look up the op-channel capability of the requested unit and mux the
  // latched unit's ready/result signals.
  always_comb begin
    req_has_op = 1'b0;
    sel_a_rdy  = 1'b0;
    sel_b_rdy  = 1'b0;
    sel_op_rdy = 1'b0;
    sel_r_vld  = 1'b0;
    sel_r_data = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (req_unit == UW'(i)) begin
        req_has_op = OP_MASK[i];
      end
      if (unit_q == UW'(i)) begin
        sel_a_rdy  = u.u_a_tready[i];
        sel_b_rdy  = u.u_b_tready[i];
        sel_op_rdy = u.u_op_tready[i];
        sel_r_vld  = u.u_r_tvalid[i];
        sel_r_data = u.u_r_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign a_fire  = (state_q == StIssue) && !a_done_q  && sel_a_rdy;
  assign b_fire  = (state_q == StIssue) && !b_done_q  && sel_b_rdy;
  assign op_fire = (state_q == StIssue) && !op_done_q && sel_op_rdy;
  assign r_fire  = (state_q == StWait)  && sel_r_vld;

  // Next-state logic for the dispatch FSM, channel tracking and watchdog.
  always_comb begin
    state_d   = state_q;
    unit_d    = unit_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    op_done_d = op_done_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          unit_d    = req_unit;
          a_d       = req_a;
          b_d       = req_b;
          op_d      = req_op;
          cnt_d     = '0;
          a_done_d  = 1'b0;
          b_done_d  = 1'b0;
          // Units without an op port have nothing to send on that channel.
          op_done_d = !req_has_op;
          if (!req_legal) begin
            result_d = '0;
            err_d    = ErrIllegal;
            state_d  = StDone;
          end else begin
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d = cnt_q + 1'b1;
        if (a_fire)  a_done_d  = 1'b1;
        if (b_fire)  b_done_d  = 1'b1;
        if (op_fire) op_done_d = 1'b1;
        if (timeout) begin
          result_d = '0;
          err_d    = ErrTimeout;
          state_d  = StDone;
        end else if ((a_done_q || a_fire) && (b_done_q || b_fire) &&
                     (op_done_q || op_fire)) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the watchdog edge still wins.
        if (r_fire) begin
          result_d = sel_r_data;
          err_d    = ErrOk;
          state_d  = StDone;
        end else if (timeout) begin
          result_d = '0;
          err_d    = ErrTimeout;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Drive only the latched unit's channels; everything else stays at zero.
  always_comb begin
    u.u_a_tdata   = '0;
    u.u_a_tvalid  = '0;
    u.u_b_tdata   = '0;
    u.u_b_tvalid  = '0;
    u.u_op_tdata  = '0;
    u.u_op_tvalid = '0;
    u.u_r_tready  = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (unit_q == UW'(i)) begin
        if (state_q == StIssue) begin
          u.u_a_tdata[i*DATA_W +: DATA_W] = a_q;
          u.u_b_tdata[i*DATA_W +: DATA_W] = b_q;
          u.u_a_tvalid[i]                 = !a_done_q;
          u.u_b_tvalid[i]                 = !b_done_q;
          if (OP_MASK[i]) begin
            u.u_op_tdata[i*OP_W +: OP_W] = op_q;
            u.u_op_tvalid[i]             = !op_done_q;
          end
        end
        if (state_q == StWait) begin
          u.u_r_tready[i] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      unit_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      op_done_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      err_q     <= ErrOk;
    end else begin
      state_q   <= state_d;
      unit_q    <= unit_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      op_done_q <= op_done_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Parametrised single-issue dispatcher between the core execute stage and a bank of AXI-Stream floating-point operator units (add/sub, mul, div, compare, convert, sqrt, …). It accepts one request at a time, drives the operand and op channels of the selected unit with full per-channel valid/ready handshaking, and waits for the result. It then returns the result with a single-cycle done pulse. A watchdog aborts any unit that stops responding.

## Interface
- NUM_UNITS, 7: number of attached operator units; must be >= 1.
- DATA_W, 32: operand/result width.
- OP_W, 8: op-channel width.
- OP_MASK, 7'b0001001: bit u=1 means unit u has an op channel; width NUM_UNITS.
- TIMEOUT_CYC, 1023: watchdog limit in cycles, >= 2; a counter of clog2(TIMEOUT_CYC+1) bits.
- UW: localparam = max(1, clog2(NUM_UNITS)).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_unit  in  UW  target unit index.
- req_a, req_b  in  DATA_W each  operands.
- req_op  in  OP_W  op code, ignored for units without an op channel.
- stall  in  1  blocks acceptance of a new request.
- req_ready  out  1  high in IDLE when stall=0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  captured result, held until the next done.
- err  out  2  set with done: 00 ok, 01 timeout, 10 illegal unit.
- u_a_tdata, u_b_tdata  out  NUM_UNITS*DATA_W  operand buses; unit u occupies slice [u*DATA_W +: DATA_W].
- u_a_tvalid, u_b_tvalid  out  NUM_UNITS  operand valids.
- u_a_tready, u_b_tready  in  NUM_UNITS  operand readies.
- u_op_tdata  out  NUM_UNITS*OP_W  op buses.
- u_op_tvalid  out  NUM_UNITS  op valids.
- u_op_tready  in  NUM_UNITS  op readies.
- u_r_tdata  in  NUM_UNITS*DATA_W  result buses.
- u_r_tvalid  in  NUM_UNITS  result valids.
- u_r_tready  out  NUM_UNITS  result readies.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - A request is accepted at a rising edge when req_valid=1 and req_ready=1.
  - On acceptance, latch unit, a, b and op, and clear the watchdog.
  - If req_unit >= NUM_UNITS, go straight to DONE with err=10 and result=0.
  - Otherwise go to ISSUE.
- ISSUE:
  - For the latched unit only, drive u_a_tvalid, u_b_tvalid and u_op_tvalid (op only if OP_MASK[u]) with the latched data.
  - Each channel drops its tvalid on the cycle after its own valid&ready edge; channels complete independently and in any order.
  - A channel without an op port counts as complete immediately.
  - Once all channels are complete, go to WAIT.
  - tdata stays stable while its tvalid is high.
- WAIT:
  - u_r_tready[u]=1.
  - On the edge where u_r_tvalid[u]=1, capture u_r_tdata slice u into result, set err=00, go to DONE.
  - The unit is expected to hold u_r_tvalid for at most one beat after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE.
- Non-selected units: tvalid=0, r_tready=0, tdata=0 at all times.
- Watchdog:
  - Counts every cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT_CYC: drop all valids/readies, result=0, err=01, go to DONE.
- stall: only gates acceptance in IDLE; an in-flight operation ignores it.
- result and err keep their values until the next DONE.

## Timing
- Reset (RST_N=0 at an edge) forces:
  - state IDLE;
  - all u_*_tvalid=0, u_r_tready=0, u_*_tdata=0;
  - done=0, busy=0, result=0, err=00.
  - req_ready follows as 1 when stall=0.
- Reset mid-operation: the operation is abandoned and no done pulse is produced; a unit is left holding an unconsumed result.
- Minimum latency, with all readies high and r_tvalid ready immediately:
  - request accepted at edge k;
  - ISSUE during cycle k+1 (valids high);
  - WAIT during cycle k+2 with r_tready high, result captured at edge k+3;
  - done high in cycle k+3;
  - req_ready high in cycle k+4, so back-to-back issue interval is 4 cycles.
- A result beat that arrives while the dispatcher is still in ISSUE is not consumed until WAIT, because r_tready stays 0 in ISSUE.
- Timeout fires on the edge where the counter equals TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after leaving IDLE; done follows in the next cycle.
- Illegal unit: done in cycle k+1 after acceptance.

## Test plan
- Unit 0 (add, op channel): a=0x3F800000, b=0x40000000, op=0x00, model returns 0x40400000 at once -> done in cycle k+3, result=0x40400000, err=00, only unit 0 valids toggle.
- Unit 2 (div, no op channel): a_tready held low 5 cycles, b_tready immediate -> a_tvalid stays high 6 cycles with stable data, b_tvalid drops after 1 cycle, u_op_tvalid[2] never asserts, completion correct.
- TIMEOUT_CYC=16, unit 4 never raises r_tvalid -> done 17 cycles after acceptance, err=01, result=0, r_tready[4] low afterwards.
- req_unit=7 with NUM_UNITS=7 -> done in cycle k+1, err=10, result=0, no unit valids asserted.
- stall=1 with req_valid=1 -> req_ready=0 and no issue; stall raised during WAIT -> operation still completes normally.
- RST_N asserted in WAIT -> next cycle all outputs at reset values, no done pulse; a fresh request afterwards completes correctly.
